rap_err_acc: RTL
================

Name: rap_err_acc

Overview:
- Error-metric accumulator placed directly downstream of the 16-bit RAP-CLA approximate adder.
- Each accepted sample carries the operand pair and the adder's 17-bit approximate sum.
- Per sample, the block computes the exact sum and the absolute error distance (ED), then accumulates characterisation statistics over a programmed number of samples.
- Statistics: sample count, erroneous-sample count, ED sum, max ED. Results feed the evaluation harness that reports error rate and mean error distance.

Parameters:
W, 16, operand width; approximate and exact sums are W+1 bits
CNT_W, 32, width of sample and error counters and of n_samples
ACC_W, 48, width of the ED sum accumulator

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a new measurement run
n_samples  input  CNT_W  samples per run; sampled on start
in_valid  input  1  sample valid from adder stage
in_ready  output  1  block can accept a sample
a  input  W  operand A presented to the adder
b  input  W  operand B presented to the adder
approx_sum  input  W+1  approximate adder output for (a,b)
busy  output  1  run in progress
done  output  1  results valid; held until next start
sample_cnt  output  CNT_W  samples accepted this run
err_cnt  output  CNT_W  samples with ED != 0
ed_sum  output  ACC_W  sum of ED, saturating
ed_max  output  W+1  maximum ED seen this run

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=0, busy=0, done=0. All counters, ed_sum, ed_max and the latched target = 0.
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE --start--> RUN when n_samples != 0.
  - IDLE/DONE --start with n_samples==0--> DONE, with all statistics cleared to 0.
  - RUN --final accept--> DONE.
  - DONE --start--> RUN or DONE per the two rules above.
- start in any state clears all statistics and latches n_samples on that same edge.
- start during RUN aborts the current run and restarts immediately. The sample handshaking on the start cycle is discarded.
- in_ready = 1 only in RUN and not on a start cycle. busy = (state==RUN). done = (state==DONE).
- Accept = in_valid & in_ready. Samples with in_valid while in_ready=0 are ignored and not held; the upstream stage must hold them.
- On accept, all of the following update on the same clock edge (one-cycle latency from accept to visible outputs):
  - exact = a + b, zero-extended to W+1 bits.
  - ED = |exact - approx_sum|, unsigned, W+1 bits.
  - sample_cnt += 1.
  - err_cnt += (ED != 0).
  - ed_sum += ED, saturating at 2^ACC_W - 1.
  - ed_max = max(ed_max, ED).
- Final accept: when the accept makes sample_cnt equal to the latched target, the state becomes DONE on the same edge. in_ready drops the next cycle; no extra sample is taken.
- Counters never wrap: at most the target number of accepts occur per run.
- Outputs are registered and stable in IDLE and DONE. They update during RUN as samples arrive.
- Reset asserted mid-run clears everything asynchronously. After release, the block sits in IDLE until the next start.

Test Plan:
- Reset check: assert rst_n=0 mid-RUN after 3 accepts -> outputs immediately 0, in_ready=0. After release, state IDLE, done=0.
- Single erroneous sample: start with n_samples=1; a=0x000F, b=0x0001, approx_sum=0x00000 -> next cycle done=1, sample_cnt=1, err_cnt=1, ed_sum=16, ed_max=16, in_ready=0.
- Exact samples: n_samples=4; (0x0007,0x0001,0x00008), (0x1234,0x0001,0x01235), (0xFFFF,0x0001,0x10000), (0,0,0) -> err_cnt=0, ed_sum=0, ed_max=0, sample_cnt=4, done=1.
- Handshake gaps: n_samples=3 with in_valid toggled 1,0,0,1,1,1 and a/b fixed -> exactly 3 accepts counted, the 6th valid not accepted, done asserts the cycle after the 5th.
- Mixed errors and max tracking: n_samples=3 with ED 16, 0, 4096 (e.g. approx_sum = exact - 4096) -> err_cnt=2, ed_sum=4112, ed_max=4096.
- Restart and zero-length run: start mid-run after 2 samples -> stats cleared, new target latched. Then start with n_samples=0 -> done=1 next cycle, all stats 0, in_ready never asserted.

Source files
------------

// File: rtl/rap_err_acc.sv
// Error-metric accumulator for the RAP-CLA approximate adder: per accepted sample it
// forms the exact sum and error distance and keeps count/error/sum/max statistics per run.
module rap_err_acc #(
    parameter int W     = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W:0]       approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [W:0]       ed_max
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [W:0]       max_q, max_d;

    logic [W:0] exact;
    logic [W:0] ed;
    logic       accept;

    function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [W:0]       inc);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + {{(ACC_W-W){1'b0}}, inc};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // A start cycle never accepts: its handshake is discarded in favour of the restart.
    assign in_ready = (state_q == S_RUN) && !start;
    assign accept   = in_valid && in_ready;
    assign exact    = {1'b0, a} + {1'b0, b};
    assign ed       = abs_diff(exact, approx_sum);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sum_d    = sum_q;
        max_d    = max_q;
        if (start) begin
            target_d = n_samples;
            cnt_d    = '0;
            err_d    = '0;
            sum_d    = '0;
            max_d    = '0;
            state_d  = (n_samples != '0) ? S_RUN : S_DONE;
        end else if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            err_d = err_q + {{(CNT_W-1){1'b0}}, (ed != '0)};
            sum_d = sat_add(sum_q, ed);
            max_d = (ed > max_q) ? ed : max_q;
            if (cnt_d == target_q) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            sum_q    <= '0;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sum_q    <= sum_d;
            max_q    <= max_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign sample_cnt = cnt_q;
    assign err_cnt    = err_q;
    assign ed_sum     = sum_q;
    assign ed_max     = max_q;

endmodule
